inst_axi_bridge: RTL and testbench

INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

---
 rtl/inst_axi_bridge_if.sv | 62 ++++++
 rtl/inst_axi_bridge.sv | 123 ++++++++++++
 tb/tb_inst_axi_bridge.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_bridge_if.sv
// Bus interfaces for the instruction-fetch AXI bridge.
// inst_sram_if : SRAM-like request/response channel between fetch stage (master) and bridge (slave).
// axi_rd_if    : AXI read address/data channels between bridge (master) and memory (slave).

interface inst_sram_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  // Fetch-stage view: issues requests, receives acceptance and data
  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  // Bridge view: accepts requests, returns data
  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // Read-master view (the bridge)
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  // Read-slave view (the memory / interconnect)
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// Instruction-fetch bridge: converts SRAM-like fetch requests into single-beat
// AXI reads, one transaction outstanding at a time (IDLE -> AR -> R -> IDLE).
// Write requests are never serviced; they and non-OKAY responses raise a
// sticky bus_err flag that only reset clears.

module inst_axi_bridge #(
  parameter logic [3:0] AR_ID     = 4'd0,
  parameter logic [3:0] AXI_CACHE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  inst_sram_if.slave  sram,
  axi_rd_if.master    axi,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        dataOk_q, dataOk_d;
  logic        busErr_q, busErr_d;

  logic        writeReq;
  logic        accept;
  logic        arHandshake;
  logic        rHandshake;

  // Register update: all state is synchronously reset to IDLE / zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      size_q   <= 2'd0;
      rdata_q  <= 32'd0;
      dataOk_q <= 1'b0;
      busErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      rdata_q  <= rdata_d;
      dataOk_q <= dataOk_d;
      busErr_q <= busErr_d;
    end
  end

  // Next-state and handshake decode; a write request in IDLE is refused and flagged
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    rdata_d     = rdata_q;
    dataOk_d    = 1'b0;
    busErr_d    = busErr_q;

    writeReq    = (state_q == IDLE) && sram.inst_sram_req && sram.inst_sram_wr;
    accept      = (state_q == IDLE) && sram.inst_sram_req && !sram.inst_sram_wr;
    arHandshake = (state_q == AR) && axi.arready;
    rHandshake  = (state_q == R) && axi.rvalid;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = sram.inst_sram_addr;
          size_d  = sram.inst_sram_size;
          state_d = AR;
        end
        if (writeReq) begin
          busErr_d = 1'b1;
        end
      end
      AR: begin
        if (arHandshake) begin
          state_d = R;
        end
      end
      R: begin
        if (rHandshake) begin
          rdata_d  = axi.rdata;
          dataOk_d = 1'b1;
          state_d  = IDLE;
          if (axi.rresp != 2'b00) begin
            busErr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM-side outputs: acceptance is combinational in IDLE, data comes from the capture register
  always_comb begin
    sram.inst_sram_addr_ok = (state_q == IDLE) && !(sram.inst_sram_req && sram.inst_sram_wr);
    sram.inst_sram_data_ok = dataOk_q;
    sram.inst_sram_rdata   = rdata_q;
  end

  // AXI read-master outputs: address fields straight from registers so they hold under back-pressure
  always_comb begin
    axi.arid    = AR_ID;
    axi.araddr  = addr_q;
    axi.arlen   = 8'd0;
    axi.arsize  = {1'b0, size_q};
    axi.arburst = 2'b01;
    axi.arlock  = 2'b00;
    axi.arcache = AXI_CACHE;
    axi.arprot  = 3'b000;
    axi.arvalid = (state_q == AR);
    axi.rready  = (state_q == R);
  end

  assign bus_err = busErr_q;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed self-checking bench for inst_axi_bridge: single fetch, back-pressure,
// back-to-back fetch, error/write handling and reset mid-transaction.

module tb_inst_axi_bridge;

  logic clk;
  logic reset;
  logic busErr;
  int   errors;
  int   checks;
  int   okCount;

  inst_sram_if sramIf ();
  axi_rd_if    axiIf ();

  inst_axi_bridge #(
    .AR_ID(4'd0),
    .AXI_CACHE(4'd0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sram(sramIf),
    .axi(axiIf),
    .bus_err(busErr)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, then settle 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the fetch-side request fields
  task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                               input logic [1:0] size);
    sramIf.inst_sram_req  = req;
    sramIf.inst_sram_wr   = wr;
    sramIf.inst_sram_addr = addr;
    sramIf.inst_sram_size = size;
    #1;
  endtask

  // One comparison: counts it, and on mismatch counts a failure and reports it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    sramIf.inst_sram_req   = 1'b0;
    sramIf.inst_sram_wr    = 1'b0;
    sramIf.inst_sram_size  = 2'd0;
    sramIf.inst_sram_wstrb = 4'd0;
    sramIf.inst_sram_addr  = 32'd0;
    sramIf.inst_sram_wdata = 32'd0;
    axiIf.arready = 1'b0;
    axiIf.rid     = 4'd0;
    axiIf.rdata   = 32'd0;
    axiIf.rresp   = 2'b00;
    axiIf.rlast   = 1'b1;
    axiIf.rvalid  = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_arvalid", 32'(axiIf.arvalid), 32'd0);
    checkOutput("rst_rready", 32'(axiIf.rready), 32'd0);
    checkOutput("rst_data_ok", 32'(sramIf.inst_sram_data_ok), 32'd0);
    checkOutput("rst_rdata", sramIf.inst_sram_rdata, 32'd0);
    checkOutput("rst_araddr", axiIf.araddr, 32'd0);
    checkOutput("rst_bus_err", 32'(busErr), 32'd0);
    checkOutput("rst_addr_ok", 32'(sramIf.inst_sram_addr_ok), 32'd1);

    // ---- single fetch ----
    applyStimulus(1'b1, 1'b0, 32'hBFC00000, 2'd2);
    checkOutput("f1_addr_ok", 32'(sramIf.inst_sram_addr_ok), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
    checkOutput("f1_arvalid", 32'(axiIf.arvalid), 32'd1);
    checkOutput("f1_araddr", axiIf.araddr, 32'hBFC00000);
    checkOutput("f1_arsize", 32'(axiIf.arsize), 32'd2);
    checkOutput("f1_arlen", 32'(axiIf.arlen), 32'd0);
    checkOutput("f1_arburst", 32'(axiIf.arburst), 32'd1);
    checkOutput("f1_arid", 32'(axiIf.arid), 32'd0);
    checkOutput("f1_arcache", 32'(axiIf.arcache), 32'd0);
    checkOutput("f1_addr_ok_busy", 32'(sramIf.inst_sram_addr_ok), 32'd0);
    checkOutput("f1_rready_in_ar", 32'(axiIf.rready), 32'd0);
    axiIf.arready = 1'b1;
    tick();
    axiIf.arready = 1'b0;
    axiIf.rvalid  = 1'b1;
    axiIf.rdata   = 32'h3C080001;
    #1;
    checkOutput("f1_rready", 32'(axiIf.rready), 32'd1);
    checkOutput("f1_arvalid_low", 32'(axiIf.arvalid), 32'd0);
    checkOutput("f1_data_ok_early", 32'(sramIf.inst_sram_data_ok), 32'd0);
    tick();
    axiIf.rvalid = 1'b0;
    #1;
    checkOutput("f1_data_ok", 32'(sramIf.inst_sram_data_ok), 32'd1);
    checkOutput("f1_rdata", sramIf.inst_sram_rdata, 32'h3C080001);
    checkOutput("f1_addr_ok_idle", 32'(sramIf.inst_sram_addr_ok), 32'd1);
    tick();
    checkOutput("f1_data_ok_once", 32'(sramIf.inst_sram_data_ok), 32'd0);
    checkOutput("f1_rdata_hold", sramIf.inst_sram_rdata, 32'h3C080001);

    // ---- back-pressure ----
    applyStimulus(1'b1, 1'b0, 32'hBFC00010, 2'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_arvalid", 32'(axiIf.arvalid), 32'd1);
      checkOutput("bp_araddr", axiIf.araddr, 32'hBFC00010);
      checkOutput("bp_addr_ok_ar", 32'(sramIf.inst_sram_addr_ok), 32'd0);
      tick();
    end
    axiIf.arready = 1'b1;
    #1;
    checkOutput("bp_arvalid_hs", 32'(axiIf.arvalid), 32'd1);
    tick();
    axiIf.arready = 1'b0;
    okCount = 0;
    for (int i = 0; i < 7; i++) begin
      checkOutput("bp_rready", 32'(axiIf.rready), 32'd1);
      checkOutput("bp_addr_ok_r", 32'(sramIf.inst_sram_addr_ok), 32'd0);
      okCount += 32'(sramIf.inst_sram_data_ok);
      tick();
    end
    axiIf.rvalid = 1'b1;
    axiIf.rdata  = 32'h11112222;
    tick();
    axiIf.rvalid = 1'b0;
    #1;
    checkOutput("bp_rdata", sramIf.inst_sram_rdata, 32'h11112222);
    for (int i = 0; i < 4; i++) begin
      okCount += 32'(sramIf.inst_sram_data_ok);
      tick();
    end
    checkOutput("bp_data_ok_count", 32'(okCount), 32'd1);

    // ---- back-to-back fetch ----
    applyStimulus(1'b1, 1'b0, 32'hBFC00000, 2'd2);
    tick();
    applyStimulus(1'b1, 1'b0, 32'hBFC00004, 2'd2);
    checkOutput("b2b_araddr_a", axiIf.araddr, 32'hBFC00000);
    axiIf.arready = 1'b1;
    tick();
    axiIf.arready = 1'b0;
    axiIf.rvalid  = 1'b1;
    axiIf.rdata   = 32'hAAAA0001;
    tick();
    axiIf.rvalid = 1'b0;
    #1;
    checkOutput("b2b_data_ok_a", 32'(sramIf.inst_sram_data_ok), 32'd1);
    checkOutput("b2b_rdata_a", sramIf.inst_sram_rdata, 32'hAAAA0001);
    checkOutput("b2b_addr_ok_with_data_ok", 32'(sramIf.inst_sram_addr_ok), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
    checkOutput("b2b_arvalid_b", 32'(axiIf.arvalid), 32'd1);
    checkOutput("b2b_araddr_b", axiIf.araddr, 32'hBFC00004);
    checkOutput("b2b_data_ok_gap", 32'(sramIf.inst_sram_data_ok), 32'd0);
    axiIf.arready = 1'b1;
    tick();
    axiIf.arready = 1'b0;
    axiIf.rvalid  = 1'b1;
    axiIf.rdata   = 32'hBBBB0002;
    tick();
    axiIf.rvalid = 1'b0;
    #1;
    checkOutput("b2b_data_ok_b", 32'(sramIf.inst_sram_data_ok), 32'd1);
    checkOutput("b2b_rdata_b", sramIf.inst_sram_rdata, 32'hBBBB0002);
    tick();

    // ---- error response ----
    applyStimulus(1'b1, 1'b0, 32'hBFC00020, 2'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
    axiIf.arready = 1'b1;
    tick();
    axiIf.arready = 1'b0;
    axiIf.rvalid  = 1'b1;
    axiIf.rresp   = 2'b10;
    axiIf.rdata   = 32'hDEAD0003;
    #1;
    checkOutput("err_bus_err_before", 32'(busErr), 32'd0);
    tick();
    axiIf.rvalid = 1'b0;
    axiIf.rresp  = 2'b00;
    #1;
    checkOutput("err_data_ok", 32'(sramIf.inst_sram_data_ok), 32'd1);
    checkOutput("err_rdata", sramIf.inst_sram_rdata, 32'hDEAD0003);
    checkOutput("err_bus_err", 32'(busErr), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("err_bus_err_sticky", 32'(busErr), 32'd1);
    checkOutput("err_no_retry", 32'(axiIf.arvalid), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("err_bus_err_cleared", 32'(busErr), 32'd0);

    // ---- write request refused ----
    applyStimulus(1'b1, 1'b1, 32'hBFC00040, 2'd2);
    checkOutput("wr_addr_ok", 32'(sramIf.inst_sram_addr_ok), 32'd0);
    tick();
    checkOutput("wr_arvalid", 32'(axiIf.arvalid), 32'd0);
    checkOutput("wr_bus_err", 32'(busErr), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
    checkOutput("wr_still_idle", 32'(sramIf.inst_sram_addr_ok), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;

    // ---- reset in R, then stray rvalid ----
    applyStimulus(1'b1, 1'b0, 32'hBFC00030, 2'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
    axiIf.arready = 1'b1;
    tick();
    axiIf.arready = 1'b0;
    #1;
    checkOutput("rr_in_r", 32'(axiIf.rready), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rr_addr_ok", 32'(sramIf.inst_sram_addr_ok), 32'd1);
    checkOutput("rr_rready", 32'(axiIf.rready), 32'd0);
    checkOutput("rr_araddr", axiIf.araddr, 32'd0);
    axiIf.rvalid = 1'b1;
    axiIf.rdata  = 32'h55555555;
    tick();
    axiIf.rvalid = 1'b0;
    #1;
    checkOutput("rr_no_data_ok", 32'(sramIf.inst_sram_data_ok), 32'd0);
    checkOutput("rr_rdata", sramIf.inst_sram_rdata, 32'd0);
    checkOutput("rr_idle", 32'(sramIf.inst_sram_addr_ok), 32'd1);
    checkOutput("rr_arvalid", 32'(axiIf.arvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
